// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: frame sequencer for the 32-point radix-2 SDF FFT pipeline and its bit-reversal sorter
module fft_seq_ctrl #(
  parameter int STAGE_LAT = 1,
  parameter int SORT_OFS  = 0,
  parameter int SORT_CYC  = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        pipe_en,
  output logic [4:0]  bf_en,
  output logic [19:0] tw_idx,
  output logic        out_valid,
  output logic        start_sorting,
  output logic        frame_done,
  output logic        busy
);
  localparam int OFF5 = 31 + 5 * STAGE_LAT;
  typedef enum logic [1:0] {LOAD, FLUSH, WAIT, DONE} state_t;
  state_t      state;
  logic [6:0]  t;
  logic [15:0] w;
  logic        act;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
      t     <= '0;
      w     <= '0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          t <= t + 7'd1;
          if (t == 7'd31) state <= FLUSH;
        end
        FLUSH: begin
          t <= t + 7'd1;
          if (t == 7'(OFF5 + 31)) begin
            state <= WAIT;
            w     <= '0;
          end
        end
        WAIT: if (w == 16'(SORT_CYC - 1)) state <= DONE;
              else w <= w + 16'd1;
        DONE: begin
          state <= LOAD;
          t     <= '0;
        end
        default: state <= LOAD;
      endcase
    end
  end
  assign act           = (state == LOAD) || (state == FLUSH);
  assign in_ready      = state == LOAD;
  // rst gates the only combinational in_valid path so everything reads idle during reset
  assign pipe_en       = rst && ((state == FLUSH) || (state == LOAD && in_valid));
  assign out_valid     = pipe_en && (t >= 7'(OFF5)) && (t <= 7'(OFF5 + 31));
  assign start_sorting = (state == FLUSH) && (t == 7'(OFF5 + SORT_OFS));
  assign frame_done    = state == DONE;
  assign busy          = state != LOAD;
  for (genvar s = 0; s < 5; s++) begin : g_stage
    localparam int OFF = 32 - (32 >> s) + s * STAGE_LAT;
    logic [7:0] c;
    logic       win;
    assign c    = {1'b0, t} - 8'(OFF);
    assign win  = ({1'b0, t} >= 8'(OFF)) && (c <= 8'd31);
    assign bf_en[s] = act && win && c[4-s];
    assign tw_idx[4*s +: 4] = bf_en[s] ? (c[3:0] & 4'((16 >> s) - 1)) << s : 4'd0;
  end
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: two parameterisations driven together, checked each cycle against a frame-timeline model
module tb_fft_seq_ctrl;
  localparam int SORT_CYC = 33;
  typedef struct packed {
    logic        in_ready;
    logic        pipe_en;
    logic [4:0]  bf_en;
    logic [19:0] tw_idx;
    logic        out_valid;
    logic        start_sorting;
    logic        frame_done;
    logic        busy;
  } obs_t;
  logic clk = 0, rst = 0, iv = 0;
  logic ir_a, pe_a, ov_a, ss_a, fd_a, bz_a, ir_b, pe_b, ov_b, ss_b, fd_b, bz_b;
  logic [4:0] bf_a, bf_b;
  logic [19:0] tw_a, tw_b;
  obs_t got_a, got_b;
  int checks = 0, errors = 0, cyc = 0;
  int n[2], k[2], st[2], gaps[2], pulses[2];
  int sl[2] = '{1, 2};
  int so[2] = '{0, 3};
  assign got_a = {ir_a, pe_a, bf_a, tw_a, ov_a, ss_a, fd_a, bz_a};
  assign got_b = {ir_b, pe_b, bf_b, tw_b, ov_b, ss_b, fd_b, bz_b};
  fft_seq_ctrl dut_a (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir_a), .pipe_en(pe_a), .bf_en(bf_a),
    .tw_idx(tw_a), .out_valid(ov_a), .start_sorting(ss_a), .frame_done(fd_a), .busy(bz_a)
  );
  fft_seq_ctrl #(.STAGE_LAT(2), .SORT_OFS(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir_b), .pipe_en(pe_b), .bf_en(bf_b),
    .tw_idx(tw_b), .out_valid(ov_b), .start_sorting(ss_b), .frame_done(fd_b), .busy(bz_b)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // n = pipeline advances in this frame, k = idle cycles after the last output sample
  function automatic obs_t model(int lat, int ofs, int nn, int kk, logic v, logic rn);
    obs_t e = '0;
    int o5 = 31 + 5 * lat;
    bit load = nn < 32;
    bit flush = !load && nn < o5 + 32;
    e.in_ready = load;
    e.pipe_en = rn && (flush || (load && v));
    e.busy = !load;
    e.frame_done = !load && !flush && kk == SORT_CYC;
    e.out_valid = flush && nn >= o5;
    e.start_sorting = flush && nn == o5 + ofs;
    if (load || flush) begin
      for (int s = 0; s < 5; s++) begin
        int len = 16 >> s;
        int c = nn - (32 - 2 * len) - s * lat;
        if (c >= 0 && c < 32 && (c / len) % 2 == 1) begin
          e.bf_en[s] = 1'b1;
          e.tw_idx[4*s +: 4] = 4'((c % len) * (1 << s));
        end
      end
    end
    return e;
  endfunction
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      obs_t g, e;
      string p;
      g = (d == 0) ? got_a : got_b;
      p = (d == 0) ? "a" : "b";
      if (!rst) begin
        n[d] = 0; k[d] = 0; gaps[d] = 0; pulses[d] = 0; st[d] = -1;
      end
      e = model(sl[d], so[d], n[d], k[d], iv, rst);
      chk({p, "_in_ready"}, 32'(g.in_ready), 32'(e.in_ready));
      chk({p, "_pipe_en"}, 32'(g.pipe_en), 32'(e.pipe_en));
      chk({p, "_bf_en"}, 32'(g.bf_en), 32'(e.bf_en));
      chk({p, "_tw_idx"}, 32'(g.tw_idx), 32'(e.tw_idx));
      chk({p, "_out_valid"}, 32'(g.out_valid), 32'(e.out_valid));
      chk({p, "_start_sorting"}, 32'(g.start_sorting), 32'(e.start_sorting));
      chk({p, "_frame_done"}, 32'(g.frame_done), 32'(e.frame_done));
      chk({p, "_busy"}, 32'(g.busy), 32'(e.busy));
      if (g.start_sorting) pulses[d]++;
      if (g.frame_done) begin
        chk({p, "_latency"}, 32'(cyc - st[d]), 32'(32 + 31 + 5 * sl[d] + SORT_CYC + gaps[d]));
        chk({p, "_sort_pulses"}, 32'(pulses[d]), 32'd1);
      end
      if (rst) begin
        if (n[d] == 0 && iv) begin
          st[d] = cyc; gaps[d] = 0; pulses[d] = 0;
        end
        if (n[d] > 0 && n[d] < 32 && !iv) gaps[d]++;
        if (e.pipe_en) n[d]++;
        else if (n[d] >= 32) begin
          if (k[d] == SORT_CYC) begin
            n[d] = 0; k[d] = 0;
          end else k[d]++;
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      n[d] = 0; k[d] = 0; st[d] = -1; gaps[d] = 0; pulses[d] = 0;
    end
    repeat (3) step();
    rst = 1;
    iv = 1;
    repeat (230) step();
    rst = 0; iv = 0;
    step();
    rst = 1;
    for (int i = 0; i < 140; i++) begin
      iv = !(i >= 10 && i < 15);
      step();
    end
    rst = 0;
    repeat (2) step();
    rst = 1; iv = 1;
    repeat (40) step();
    rst = 0;
    step();
    rst = 1;
    repeat (120) step();
    for (int i = 0; i < 2000; i++) begin
      iv = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 499) != 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
